// File: rtl/ldpc_minsum_decoder.sv
// Iterative min-sum LDPC decoder with a flooding schedule: one cycle per check half-iteration, one per variable half-iteration.
// Define LDPC_EARLY_TERM_EN to stop as soon as the hard decision satisfies every parity check.
module ldpc_minsum_decoder #(
  parameter int N        = 10,
  parameter int M        = 5,
  parameter int LLR_W    = 8,
  parameter int MAX_ITER = 8,
  parameter logic [M*N-1:0] H_MATRIX = {10'h348, 10'h2a4, 10'h192, 10'h071, 10'h00f}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] rx_bits,
  input  logic [7:0]   err_llr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] dec_bits,
  output logic [7:0]   iter_count,
  output logic         syndrome_ok
);

  localparam int MAXV  = (1 << (LLR_W - 1)) - 1;
  localparam int SUM_W = LLR_W + $clog2(M + 1) + 1;
  localparam logic signed [LLR_W-1:0] LLR_MAX = LLR_W'(MAXV);
  localparam logic signed [SUM_W-1:0] SUM_HI  = SUM_W'(MAXV);
  localparam logic signed [SUM_W-1:0] SUM_LO  = -SUM_W'(MAXV);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CHK  = 3'd2,
    VAR  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Symmetric clamp keeps -2^(LLR_W-1) out of every message so negation never overflows.
  function automatic logic signed [LLR_W-1:0] sat_llr(input logic signed [SUM_W-1:0] x);
    logic signed [LLR_W-1:0] y;
    if (x > SUM_HI) begin
      y = LLR_MAX;
    end else if (x < SUM_LO) begin
      y = -LLR_MAX;
    end else begin
      y = x[LLR_W-1:0];
    end
    return y;
  endfunction

  function automatic logic [M-1:0] syndrome_of(input logic [N-1:0] bits);
    logic [M-1:0] s;
    s = '0;
    for (int r = 0; r < M; r++) begin
      s[r] = ^(bits & H_MATRIX[r*N +: N]);
    end
    return s;
  endfunction

  state_t                  state_r;
  logic [N-1:0]            rx_r;
  logic [7:0]              err_r;
  logic signed [LLR_W-1:0] chan_r      [N];
  logic signed [LLR_W-1:0] c2v_r       [M][N];
  logic signed [LLR_W-1:0] v2c_r       [M][N];
  logic signed [LLR_W-1:0] c2v_s       [M][N];
  logic signed [LLR_W-1:0] v2c_s       [M][N];
  logic signed [LLR_W-1:0] v2c_load_s  [M][N];
  logic signed [LLR_W-1:0] chan_load_s [N];
  logic signed [LLR_W-1:0] belief_s    [N];
  logic [LLR_W-1:0]        ch_mag_s;
  logic [N-1:0]            hard_s;
  logic [7:0]              iter_next_s;
  logic                    syn_ok_s;
  logic                    early_load_s;
  logic                    early_var_s;
  logic                    out_valid_r;
  logic [N-1:0]            dec_bits_r;
  logic [7:0]              iter_count_r;
  logic                    syndrome_ok_r;

  assign in_ready    = (state_r == IDLE) && !rst;
  assign out_valid   = out_valid_r;
  assign dec_bits    = dec_bits_r;
  assign iter_count  = iter_count_r;
  assign syndrome_ok = syndrome_ok_r;

  assign ch_mag_s    = (int'(err_r) > MAXV) ? LLR_W'(MAXV) : LLR_W'(err_r);
  assign iter_next_s = iter_count_r + 8'd1;
  assign syn_ok_s    = ~|syndrome_of(hard_s);

`ifdef LDPC_EARLY_TERM_EN
  assign early_load_s = ~|syndrome_of(rx_r);
  assign early_var_s  = syn_ok_s;
`else
  assign early_load_s = 1'b0;
  assign early_var_s  = 1'b0;
`endif

  // Channel LLRs and initial variable-to-check messages from the latched packet.
  always_comb begin
    for (int v = 0; v < N; v++) begin
      chan_load_s[v] = rx_r[v] ? -$signed(ch_mag_s) : $signed(ch_mag_s);
      for (int r = 0; r < M; r++) begin
        v2c_load_s[r][v] = H_MATRIX[r*N+v] ? chan_load_s[v] : '0;
      end
    end
  end

  // Check-node update: sign parity and minimum magnitude over the other row members.
  always_comb begin
    logic             sgn;
    logic             take;
    logic [LLR_W-1:0] mag;
    logic [LLR_W-1:0] a;
    sgn  = 1'b0;
    take = 1'b0;
    mag  = '0;
    a    = '0;
    for (int r = 0; r < M; r++) begin
      for (int v = 0; v < N; v++) begin
        sgn = 1'b0;
        mag = LLR_W'(MAXV);
        for (int u = 0; u < N; u++) begin
          take = H_MATRIX[r*N+u] && (u != v);
          a    = v2c_r[r][u][LLR_W-1] ? LLR_W'(-v2c_r[r][u]) : LLR_W'(v2c_r[r][u]);
          sgn  = sgn ^ (take & v2c_r[r][u][LLR_W-1]);
          mag  = (take && (a < mag)) ? a : mag;
        end
        c2v_s[r][v] = H_MATRIX[r*N+v] ? (sgn ? -$signed(mag) : $signed(mag)) : '0;
      end
    end
  end

  // Variable-node update; non-member c2v entries are held at zero so the sum can run over every row.
  always_comb begin
    logic signed [SUM_W-1:0] acc;
    acc    = '0;
    hard_s = '0;
    for (int v = 0; v < N; v++) begin
      acc = SUM_W'(chan_r[v]);
      for (int r = 0; r < M; r++) begin
        acc = acc + SUM_W'(c2v_r[r][v]);
      end
      belief_s[v] = sat_llr(acc);
      hard_s[v]   = belief_s[v][LLR_W-1];
      for (int r = 0; r < M; r++) begin
        v2c_s[r][v] = H_MATRIX[r*N+v] ? sat_llr(acc - SUM_W'(c2v_r[r][v])) : '0;
      end
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      out_valid_r   <= 1'b0;
      dec_bits_r    <= '0;
      iter_count_r  <= 8'd0;
      syndrome_ok_r <= 1'b0;
      rx_r          <= '0;
      err_r         <= 8'd0;
      chan_r        <= '{default: '0};
      c2v_r         <= '{default: '{default: '0}};
      v2c_r         <= '{default: '{default: '0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            rx_r    <= rx_bits;
            err_r   <= err_llr;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          chan_r       <= chan_load_s;
          v2c_r        <= v2c_load_s;
          iter_count_r <= 8'd0;
          if (early_load_s) begin
            state_r       <= DONE;
            out_valid_r   <= 1'b1;
            dec_bits_r    <= rx_r;
            syndrome_ok_r <= ~|syndrome_of(rx_r);
          end else begin
            state_r <= CHK;
          end
        end
        CHK: begin
          c2v_r   <= c2v_s;
          state_r <= VAR;
        end
        VAR: begin
          v2c_r        <= v2c_s;
          iter_count_r <= iter_next_s;
          if ((iter_next_s == 8'(MAX_ITER)) || early_var_s) begin
            state_r       <= DONE;
            out_valid_r   <= 1'b1;
            dec_bits_r    <= hard_s;
            syndrome_ok_r <= syn_ok_s;
          end else begin
            state_r <= CHK;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_minsum_decoder.sv
// Directed bench for ldpc_minsum_decoder at default parameters; expectations follow
// LDPC_EARLY_TERM_EN when it is defined for the build.
module tb_ldpc_minsum_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] rx_bits;
  logic [7:0] err_llr;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] dec_bits;
  logic [7:0] iter_count;
  logic       syndrome_ok;

  int n_total = 0;
  int n_pass  = 0;
  int lat;

`ifdef LDPC_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  always #5 clk = ~clk;

  ldpc_minsum_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rx_bits    (rx_bits),
    .err_llr    (err_llr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .dec_bits   (dec_bits),
    .iter_count (iter_count),
    .syndrome_ok(syndrome_ok)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Iterations the decoder runs when the early-exit build would need et_iters.
  function automatic int exp_iters(input int et_iters);
    return ET ? et_iters : 8;
  endfunction

  task automatic wait_result(output int l);
    l = 1;
    while (out_valid !== 1'b1 && l < 60) begin
      step();
      l++;
    end
  endtask

  task automatic decode(input string tag, input logic [9:0] rx, input logic [7:0] err,
                        input logic [9:0] exp_dec, input int et_iters);
    int l;
    in_valid = 1'b1;
    rx_bits  = rx;
    err_llr  = err;
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    rx_bits  = ~rx;
    err_llr  = 8'd0;
    wait_result(l);
    check({tag, "/latency"}, 32'(l), 32'(2 + 2 * exp_iters(et_iters)));
    check({tag, "/dec_bits"}, 32'(dec_bits), 32'(exp_dec));
    check({tag, "/iter_count"}, 32'(iter_count), 32'(exp_iters(et_iters)));
    check({tag, "/syndrome_ok"}, 32'(syndrome_ok), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "/out_valid_clr"}, 32'(out_valid), 32'd0);
    check({tag, "/in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rx_bits   = 10'd0;
    err_llr   = 8'd0;
    step();
    step();
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/dec_bits", 32'(dec_bits), 32'd0);
    check("rst/iter_count", 32'(iter_count), 32'd0);
    check("rst/syndrome_ok", 32'(syndrome_ok), 32'd0);
    check("rst/in_ready_held", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("rst/in_ready_rel", 32'(in_ready), 32'd1);

    decode("clean", 10'h000, 8'd13, 10'h000, 0);
    decode("bit2", 10'h004, 8'd13, 10'h000, 1);
    decode("bit9", 10'h200, 8'd13, 10'h000, 1);
    decode("codeword", 10'h013, 8'd13, 10'h013, 0);
    decode("zero_llr", 10'h004, 8'd0, 10'h000, 1);
    decode("clamp", 10'h3ff, 8'd200, 10'h3ff, 0);
    // Every message of an all-ones word at reliability 200 must sit at -127.
    check("clamp/v2c_0_0", {24'd0, dut.v2c_r[0][0]}, 32'h81);
    check("clamp/v2c_4_9", {24'd0, dut.v2c_r[4][9]}, 32'h81);

    // Backpressure with a second packet already waiting on in_valid.
    in_valid = 1'b1;
    rx_bits  = 10'h004;
    err_llr  = 8'd13;
    step();
    rx_bits = 10'h013;
    wait_result(lat);
    check("bp/latency", 32'(lat), 32'(2 + 2 * exp_iters(1)));
    for (int i = 0; i < 5; i++) begin
      check("bp/out_valid", 32'(out_valid), 32'd1);
      check("bp/dec_bits", 32'(dec_bits), 32'd0);
      check("bp/iter_count", 32'(iter_count), 32'(exp_iters(1)));
      check("bp/in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp/out_valid_clr", 32'(out_valid), 32'd0);
    check("bp/in_ready_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    wait_result(lat);
    check("bp2/latency", 32'(lat), 32'(2 + 2 * exp_iters(0)));
    check("bp2/dec_bits", 32'(dec_bits), 32'h013);
    check("bp2/iter_count", 32'(iter_count), 32'(exp_iters(0)));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset during the third check-node cycle abandons the decode.
    in_valid = 1'b1;
    rx_bits  = 10'h004;
    err_llr  = 8'd13;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    check("abort/out_valid", 32'(out_valid), 32'd0);
    check("abort/dec_bits", 32'(dec_bits), 32'd0);
    check("abort/iter_count", 32'(iter_count), 32'd0);
    check("abort/in_ready_held", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("abort/in_ready_rel", 32'(in_ready), 32'd1);
    step();
    check("abort/no_result", 32'(out_valid), 32'd0);
    decode("post_rst", 10'h004, 8'd13, 10'h000, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
